// File: rtl/aes_ip_pkg.sv
// aes_ip_pkg: shared types and constants for the AES IP loader.
// Holds the FSM state encoding, key-size modes and the per-request word count.
package aes_ip_pkg;

    typedef enum logic [2:0] {IDLE, LATCH1, LATCH2, GAP, START_WAIT, OUT_HOLD} state_t;

    localparam logic [1:0] MODE_128  = 2'd0;
    localparam logic [1:0] MODE_128B = 2'd1;
    localparam logic [1:0] MODE_192  = 2'd2;
    localparam logic [1:0] MODE_256  = 2'd3;

    localparam logic [3:0] NW_128 = 4'd4;
    localparam logic [3:0] NW_192 = 4'd6;
    localparam logic [3:0] NW_256 = 4'd8;

    // Counts are in 32-bit words; a 64-bit bus moves two per transfer.
    function automatic logic [3:0] word_cnt(input logic d_k, input logic [1:0] mode, input int bus_w);
        logic [3:0] n;
        n = d_k ? NW_128 : (mode == MODE_192) ? NW_192 : (mode == MODE_256) ? NW_256 : NW_128;
        return (bus_w == 64) ? (n >> 1) : n;
    endfunction

endpackage

// File: rtl/aes_ip_loader_if.sv
// aes_ip_loader_if: request, core-load and result signals of the AES IP loader.
// The slave modport is the loader; the master modport is the SoC/core side.
interface aes_ip_loader_if #(parameter int BUS_W = 32);
    logic             REQ_VALID;
    logic             REQ_READY;
    logic             REQ_D_K;
    logic             REQ_E_D;
    logic [1:0]       REQ_MODE;
    logic [127:0]     IN_1;
    logic [127:0]     IN_2;
    logic [BUS_W-1:0] CORE_DATAIN;
    logic             CORE_IO_DATALATCH;
    logic             CORE_IO_DATA_RW;
    logic             CORE_START;
    logic             CORE_D_K;
    logic             CORE_E_D;
    logic [1:0]       CORE_MODE;
    logic             CORE_DATA_DONE;
    logic [127:0]     CORE_PAR_DATA;
    logic [127:0]     CORE_PAR_RANDOM;
    logic [127:0]     OUT_DATA;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             BUSY;
    logic             ERR;

    modport slave (
        input  REQ_VALID, REQ_D_K, REQ_E_D, REQ_MODE, IN_1, IN_2,
        input  CORE_DATA_DONE, CORE_PAR_DATA, CORE_PAR_RANDOM, OUT_READY,
        output REQ_READY, CORE_DATAIN, CORE_IO_DATALATCH, CORE_IO_DATA_RW, CORE_START,
        output CORE_D_K, CORE_E_D, CORE_MODE, OUT_DATA, OUT_VALID, BUSY, ERR
    );

    modport master (
        output REQ_VALID, REQ_D_K, REQ_E_D, REQ_MODE, IN_1, IN_2,
        output CORE_DATA_DONE, CORE_PAR_DATA, CORE_PAR_RANDOM, OUT_READY,
        input  REQ_READY, CORE_DATAIN, CORE_IO_DATALATCH, CORE_IO_DATA_RW, CORE_START,
        input  CORE_D_K, CORE_E_D, CORE_MODE, OUT_DATA, OUT_VALID, BUSY, ERR
    );
endinterface

// File: rtl/aes_word_sel.sv
// aes_word_sel: selects word k of the 256-bit operand, word 0 being bits 255 downward.
module aes_word_sel #(
    parameter int BUS_W = 32
) (
    input  logic [255:0]     i_op,
    input  logic [2:0]       i_k,
    output logic [BUS_W-1:0] o_word
);
    logic [255:0] w_sh;

    assign w_sh   = i_op << (i_k * BUS_W);
    assign o_word = w_sh[255 -: BUS_W];
endmodule

// File: rtl/aes_ip_loader.sv
// aes_ip_loader: serialises a key or data block into the AES core and returns the unmasked result.
// Define AES_IP_TIMEOUT_EN to add the START_WAIT watchdog that aborts and pulses ERR.
module aes_ip_loader
    import aes_ip_pkg::*;
#(
    parameter int BUS_W       = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic            CLK,
    input logic            RST,
    aes_ip_loader_if.slave bus
);
    state_t           r_state;
    logic             r_ready;
    logic             r_latch;
    logic             r_start;
    logic             r_out_valid;
    logic             r_d_k;
    logic             r_e_d;
    logic [1:0]       r_mode;
    logic [2:0]       r_k;
    logic [255:0]     r_op;
    logic [127:0]     r_out_data;
    logic [3:0]       w_n;
    logic [BUS_W-1:0] w_word;
`ifdef AES_IP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_err;
`endif

    assign w_n = word_cnt(bus.REQ_D_K, bus.REQ_MODE, BUS_W);

    aes_word_sel #(.BUS_W(BUS_W)) u_sel (
        .i_op   (r_op),
        .i_k    (r_k),
        .o_word (w_word)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_latch     <= 1'b0;
            r_start     <= 1'b0;
            r_out_valid <= 1'b0;
            r_d_k       <= 1'b0;
            r_e_d       <= 1'b0;
            r_mode      <= 2'd0;
            r_k         <= 3'd0;
            r_op        <= '0;
            r_out_data  <= '0;
`ifdef AES_IP_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
`ifdef AES_IP_TIMEOUT_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                IDLE: if (bus.REQ_VALID && r_ready) begin
                    r_d_k   <= bus.REQ_D_K;
                    r_e_d   <= bus.REQ_E_D;
                    r_mode  <= bus.REQ_MODE;
                    r_op    <= {bus.IN_1, bus.IN_2};
                    r_k     <= 3'(w_n - 4'd1);
                    r_latch <= 1'b1;
                    r_ready <= 1'b0;
                    r_state <= LATCH1;
                end
                LATCH1: r_state <= LATCH2;
                LATCH2: begin
                    r_latch <= 1'b0;
                    r_state <= GAP;
                end
                GAP: if (r_k != 3'd0) begin
                    r_k     <= r_k - 3'd1;
                    r_latch <= 1'b1;
                    r_state <= LATCH1;
                end else if (r_d_k) begin
                    r_start <= 1'b1;
                    r_state <= START_WAIT;
`ifdef AES_IP_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                end else begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                START_WAIT: if (bus.CORE_DATA_DONE) begin
                    r_out_data  <= bus.CORE_PAR_DATA ^ bus.CORE_PAR_RANDOM;
                    r_start     <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= OUT_HOLD;
                end
`ifdef AES_IP_TIMEOUT_EN
                else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    r_start <= 1'b0;
                    r_err   <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
`endif
                OUT_HOLD: if (bus.OUT_READY) begin
                    r_out_valid <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.REQ_READY         = r_ready;
    assign bus.CORE_DATAIN       = w_word;
    assign bus.CORE_IO_DATALATCH = r_latch;
    assign bus.CORE_IO_DATA_RW   = 1'b0;
    assign bus.CORE_START        = r_start;
    assign bus.CORE_D_K          = r_d_k;
    assign bus.CORE_E_D          = r_e_d;
    assign bus.CORE_MODE         = r_mode;
    assign bus.OUT_DATA          = r_out_data;
    assign bus.OUT_VALID         = r_out_valid;
    assign bus.BUSY              = (r_state != IDLE);
`ifdef AES_IP_TIMEOUT_EN
    assign bus.ERR               = r_err;
`else
    assign bus.ERR               = 1'b0;
`endif
endmodule

// File: tb/tb_aes_ip_loader.sv
// tb_aes_ip_loader: randomized and directed self-checking bench for aes_ip_loader (BUS_W=32).
// The expected word stream and result are derived from the operand and key size, not from the FSM.
module tb_aes_ip_loader;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    aes_ip_loader_if #(.BUS_W(32)) bus ();

    aes_ip_loader #(.BUS_W(32), .TIMEOUT_CYC(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int nwords(input logic d_k, input logic [1:0] mode);
        if (d_k || mode < 2'd2) return 4;
        return (mode == 2'd2) ? 6 : 8;
    endfunction

    task automatic scramble_req;
        bus.REQ_D_K  = 1'($urandom());
        bus.REQ_E_D  = 1'($urandom());
        bus.REQ_MODE = 2'($urandom());
        bus.IN_1     = rnd128();
        bus.IN_2     = rnd128();
    endtask

    task automatic accept(input logic d_k, e_d, input logic [1:0] mode, input logic [127:0] in1, in2);
        chk("req_ready_idle", 128'(bus.REQ_READY), 128'(1));
        bus.REQ_D_K   = d_k;
        bus.REQ_E_D   = e_d;
        bus.REQ_MODE  = mode;
        bus.IN_1      = in1;
        bus.IN_2      = in2;
        bus.REQ_VALID = 1'b1;
        step;
        bus.REQ_VALID = 1'b0;
        scramble_req();
    endtask

    // Words go out highest index first; word k sits at bits 255-32k downward of {IN_1,IN_2}.
    task automatic load(input logic d_k, e_d, input logic [1:0] mode, input logic [127:0] in1, in2);
        logic [255:0] op;
        logic [31:0]  w;
        int           n;
        op = {in1, in2};
        n  = nwords(d_k, mode);
        accept(d_k, e_d, mode, in1, in2);
        chk("core_d_k", 128'(bus.CORE_D_K), 128'(d_k));
        chk("core_e_d", 128'(bus.CORE_E_D), 128'(e_d));
        chk("core_mode", 128'(bus.CORE_MODE), 128'(mode));
        for (int i = 0; i < n; i++) begin
            w = 32'(op >> (224 - 32 * (n - 1 - i)));
            for (int j = 0; j < 3; j++) begin
                chk("datain", 128'(bus.CORE_DATAIN), 128'(w));
                chk("latch", 128'(bus.CORE_IO_DATALATCH), 128'(j < 2));
                chk("start_load", 128'(bus.CORE_START), 128'(0));
                chk("busy_load", 128'(bus.BUSY), 128'(1));
                bus.CORE_DATA_DONE = 1'($urandom());
                step;
            end
        end
        bus.CORE_DATA_DONE = 1'b0;
        if (d_k) begin
            chk("start_rise", 128'(bus.CORE_START), 128'(1));
        end else begin
            chk("key_ready", 128'(bus.REQ_READY), 128'(1));
            chk("key_busy", 128'(bus.BUSY), 128'(0));
            chk("key_start", 128'(bus.CORE_START), 128'(0));
        end
    endtask

    task automatic finish_data(input int wait_cyc, hold_cyc, input logic [127:0] pd, pr);
        for (int i = 0; i < wait_cyc; i++) begin
            chk("start_level", 128'(bus.CORE_START), 128'(1));
            chk("valid_early", 128'(bus.OUT_VALID), 128'(0));
            step;
        end
        bus.CORE_DATA_DONE  = 1'b1;
        bus.CORE_PAR_DATA   = pd;
        bus.CORE_PAR_RANDOM = pr;
        step;
        bus.CORE_DATA_DONE  = 1'b0;
        bus.CORE_PAR_DATA   = rnd128();
        bus.CORE_PAR_RANDOM = rnd128();
        bus.REQ_VALID       = 1'b1;
        for (int i = 0; i <= hold_cyc; i++) begin
            chk("out_valid", 128'(bus.OUT_VALID), 128'(1));
            chk("out_data", bus.OUT_DATA, pd ^ pr);
            chk("start_drop", 128'(bus.CORE_START), 128'(0));
            chk("ready_hold", 128'(bus.REQ_READY), 128'(0));
            if (i == hold_cyc) begin
                bus.OUT_READY = 1'b1;
                bus.REQ_VALID = 1'b0;
            end
            step;
        end
        bus.OUT_READY = 1'b0;
        chk("valid_clear", 128'(bus.OUT_VALID), 128'(0));
        chk("ready_back", 128'(bus.REQ_READY), 128'(1));
        chk("busy_idle", 128'(bus.BUSY), 128'(0));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, 128'(bus.REQ_READY), 128'(1));
        chk({tag, "_busy"}, 128'(bus.BUSY), 128'(0));
        chk({tag, "_start"}, 128'(bus.CORE_START), 128'(0));
        chk({tag, "_latch"}, 128'(bus.CORE_IO_DATALATCH), 128'(0));
        chk({tag, "_datain"}, 128'(bus.CORE_DATAIN), 128'(0));
        chk({tag, "_valid"}, 128'(bus.OUT_VALID), 128'(0));
        chk({tag, "_odata"}, bus.OUT_DATA, 128'(0));
        chk({tag, "_err"}, 128'(bus.ERR), 128'(0));
        chk({tag, "_rw"}, 128'(bus.CORE_IO_DATA_RW), 128'(0));
    endtask

    initial begin
        logic       d_k;
        logic [1:0] mode;
        bus.REQ_VALID       = 1'b0;
        bus.REQ_D_K         = 1'b0;
        bus.REQ_E_D         = 1'b0;
        bus.REQ_MODE        = 2'd0;
        bus.IN_1            = '0;
        bus.IN_2            = '0;
        bus.CORE_DATA_DONE  = 1'b0;
        bus.CORE_PAR_DATA   = '0;
        bus.CORE_PAR_RANDOM = '0;
        bus.OUT_READY       = 1'b0;
        step;
        step;
        chk_reset_outs("rst");
        RST = 1'b1;

        load(1'b1, 1'b0, 2'd0, 128'h00112233_44556677_8899AABB_CCDDEEFF, rnd128());
        finish_data(2, 5, {32{4'hF}}, {16{8'h0F}});
        load(1'b0, 1'b1, 2'd2, 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3, 128'hA4A4A4A4_A5A5A5A5_DEADBEEF_DEADBEEF);
        load(1'b0, 1'b0, 2'd3, rnd128(), rnd128());
        load(1'b0, 1'b0, 2'd0, rnd128(), rnd128());
        load(1'b1, 1'b1, 2'd3, rnd128(), rnd128());
        finish_data(0, 0, rnd128(), rnd128());

        accept(1'b1, 1'b0, 2'd0, rnd128(), rnd128());
        repeat (4) step;
        RST = 1'b0;
        step;
        chk_reset_outs("rst_load");
        RST = 1'b1;
        step;
        chk("rst_load_ready", 128'(bus.REQ_READY), 128'(1));

        accept(1'b1, 1'b0, 2'd1, rnd128(), rnd128());
        repeat (12) step;
        chk("pre_rst_start", 128'(bus.CORE_START), 128'(1));
        RST = 1'b0;
        step;
        chk_reset_outs("rst_wait");
        RST = 1'b1;

        bus.CORE_DATA_DONE  = 1'b1;
        bus.CORE_PAR_DATA   = rnd128();
        bus.CORE_PAR_RANDOM = rnd128();
        repeat (3) begin
            step;
            chk("idle_done_valid", 128'(bus.OUT_VALID), 128'(0));
            chk("idle_done_busy", 128'(bus.BUSY), 128'(0));
        end
        bus.CORE_DATA_DONE = 1'b0;

`ifdef AES_IP_TIMEOUT_EN
        accept(1'b1, 1'b0, 2'd0, rnd128(), rnd128());
        repeat (12) step;
        for (int i = 0; i < 16; i++) begin
            chk("to_start", 128'(bus.CORE_START), 128'(1));
            chk("to_err_early", 128'(bus.ERR), 128'(0));
            step;
        end
        chk("to_err", 128'(bus.ERR), 128'(1));
        chk("to_start_drop", 128'(bus.CORE_START), 128'(0));
        chk("to_valid", 128'(bus.OUT_VALID), 128'(0));
        chk("to_ready", 128'(bus.REQ_READY), 128'(1));
        chk("to_busy", 128'(bus.BUSY), 128'(0));
        step;
        chk("to_err_pulse", 128'(bus.ERR), 128'(0));
`endif

        for (int t = 0; t < 25; t++) begin
            d_k  = 1'($urandom());
            mode = 2'($urandom());
            load(d_k, 1'($urandom()), mode, rnd128(), rnd128());
            if (d_k) finish_data($urandom_range(0, 5), $urandom_range(0, 5), rnd128(), rnd128());
            repeat ($urandom_range(0, 2)) step;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
